// File: rtl/steer_en_pkg.sv
// Shared types for the steering-enable controller: FSM state encoding.
package steer_en_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_STEER   = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

endpackage

// File: rtl/ld_cell_cmp.sv
// Combinational load-cell arithmetic: rider-presence thresholds with a
// hysteresis band and the two left/right imbalance comparisons.
module ld_cell_cmp #(
    parameter int                LD_W         = 12,
    parameter logic [LD_W-1:0]   MIN_RIDER_WT = 12'h200,
    parameter logic [LD_W-1:0]   HYST         = 12'h040
) (
    input  logic [LD_W-1:0] lft_ld,
    input  logic [LD_W-1:0] rght_ld,
    output logic            rider_on,
    output logic            rider_gone,
    output logic            diff_gt_1_4,
    output logic            diff_gt_15_16
);

    // HYST is expected not to exceed MIN_RIDER_WT, so the off threshold stays positive.
    localparam logic [LD_W:0] ON_THR  = {1'b0, MIN_RIDER_WT};
    localparam logic [LD_W:0] OFF_THR = {1'b0, MIN_RIDER_WT} - {1'b0, HYST};

    logic [LD_W:0]   sum;
    logic [LD_W-1:0] diff;
    logic [LD_W:0]   diff_x;

    always_comb begin
        sum    = {1'b0, lft_ld} + {1'b0, rght_ld};
        diff   = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
        diff_x = {1'b0, diff};

        rider_on      = (sum > ON_THR);
        rider_gone    = (sum < OFF_THR);
        diff_gt_1_4   = (diff_x > (sum >> 2));
        diff_gt_15_16 = (diff_x > (sum - (sum >> 4)));
    end

endmodule

// File: rtl/steer_en_hyst.sv
// Steering-enable FSM: waits for a rider to stand balanced for 2^TMR_W clocks
// before enabling steering, and drops out on gross imbalance or dismount.
module steer_en_hyst
    import steer_en_pkg::*;
#(
    parameter int              LD_W         = 12,
    parameter logic [LD_W-1:0] MIN_RIDER_WT = 12'h200,
    parameter logic [LD_W-1:0] HYST         = 12'h040,
    parameter int              TMR_W        = 26
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [LD_W-1:0] lft_ld,
    input  logic [LD_W-1:0] rght_ld,
    output logic            en_steer,
    output logic            rider_off,
    output logic [1:0]      state_o
);

    logic rider_on;
    logic rider_gone;
    logic diff_gt_1_4;
    logic diff_gt_15_16;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               en_steer_q;
    logic               rider_off_q;

    ld_cell_cmp #(
        .LD_W         (LD_W),
        .MIN_RIDER_WT (MIN_RIDER_WT),
        .HYST         (HYST)
    ) u_cmp (
        .lft_ld        (lft_ld),
        .rght_ld       (rght_ld),
        .rider_on      (rider_on),
        .rider_gone    (rider_gone),
        .diff_gt_1_4   (diff_gt_1_4),
        .diff_gt_15_16 (diff_gt_15_16)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!en || rider_gone) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_d = '0;
                    if (rider_on) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    // Timer only advances while balanced; reaching all-ones means settled.
                    if (diff_gt_1_4) begin
                        timer_d = '0;
                    end else if (&timer_q) begin
                        state_d = ST_STEER;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_STEER: begin
                    timer_d = '0;
                    if (diff_gt_15_16) state_d = ST_WAIT;
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            en_steer_q  <= (state_d == ST_STEER);
            rider_off_q <= (state_d == ST_IDLE);
        end
    end

    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_steer_en_hyst.sv
// Directed bench for steer_en_hyst: an arithmetic reference model checked on
// every cycle plus hand-computed milestones for settle time and hysteresis.
module tb_steer_en_hyst;

    localparam int LD_W  = 12;
    localparam int TMR_W = 8;
    localparam int MIN_W = 'h200;
    localparam int HYS_W = 'h040;
    localparam int SETTLE = 1 << TMR_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [LD_W-1:0] lft_ld;
    logic [LD_W-1:0] rght_ld;
    logic            en_steer;
    logic            rider_off;
    logic [1:0]      state_o;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model: mode 0=idle, 1=waiting, 2=steering; bal counts
    // consecutive balanced waiting cycles since the last clear.
    int m_mode = 0;
    int m_bal  = 0;

    steer_en_hyst #(
        .LD_W         (LD_W),
        .MIN_RIDER_WT (12'h200),
        .HYST         (12'h040),
        .TMR_W        (TMR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int s, d;
        s = int'(lft_ld) + int'(rght_ld);
        d = (lft_ld > rght_ld) ? int'(lft_ld) - int'(rght_ld) : int'(rght_ld) - int'(lft_ld);
        if (rst || !en || s < MIN_W - HYS_W) begin
            m_mode = 0;
            m_bal  = 0;
        end else if (m_mode == 0) begin
            if (s > MIN_W) begin
                m_mode = 1;
                m_bal  = 0;
            end
        end else if (m_mode == 1) begin
            if (d > s / 4) begin
                m_bal = 0;
            end else if (m_bal == SETTLE - 1) begin
                m_mode = 2;
                m_bal  = 0;
            end else begin
                m_bal = m_bal + 1;
            end
        end else begin
            if (d > s - s / 16) begin
                m_mode = 1;
                m_bal  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_state", {30'd0, state_o}, m_mode);
            chk("model_en_steer", {31'd0, en_steer}, (m_mode == 2) ? 1 : 0);
            chk("model_rider_off", {31'd0, rider_off}, (m_mode == 0) ? 1 : 0);
        end
    end

    task automatic set_ld(input int l, input int r);
        @(negedge clk);
        lft_ld  = LD_W'(l);
        rght_ld = LD_W'(r);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts negedges from now until en_steer is seen high, bounded.
    task automatic count_to_steer(input string name, input int budget, input int exp);
        int n;
        n = 0;
        while (en_steer !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, n, exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; lft_ld = '0; rght_ld = '0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        cycles(999);
        chk("rst_en_steer", {31'd0, en_steer}, 0);
        chk("rst_rider_off", {31'd0, rider_off}, 1);
        chk("rst_state", {30'd0, state_o}, 0);

        // In-band sum from idle must not start the settle wait.
        rst = 1'b0;
        lft_ld = 12'h100; rght_ld = 12'h100;
        cycles(3);
        chk("band_idle_state", {30'd0, state_o}, 0);

        // Balanced 0x180/0x180 enters WAIT on the next edge.
        set_ld('h180, 'h180);
        cycles(1);
        chk("enter_wait", {30'd0, state_o}, 1);
        count_to_steer("settle_cycles", 400, SETTLE);
        chk("steer_state", {30'd0, state_o}, 2);

        // Gross imbalance in STEER falls back to WAIT.
        set_ld('h700, 'h020);
        cycles(1);
        chk("imbal_state", {30'd0, state_o}, 1);
        chk("imbal_en_steer", {31'd0, en_steer}, 0);
        chk("imbal_rider_off", {31'd0, rider_off}, 0);

        // Moderate imbalance keeps clearing the timer.
        lft_ld = 12'h200; rght_ld = 12'h050;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i % 50 == 49) chk("hold_off_en_steer", {31'd0, en_steer}, 0);
        end
        rght_ld = 12'h200;
        count_to_steer("resettle_cycles", 400, SETTLE);

        // Hysteresis band: 0x1F0 holds, 0x1B0 drops to IDLE.
        set_ld('h0F8, 'h0F8);
        cycles(4);
        chk("hyst_hold_state", {30'd0, state_o}, 2);
        set_ld('h0D8, 'h0D8);
        cycles(1);
        chk("hyst_drop_state", {30'd0, state_o}, 0);
        chk("hyst_drop_rider_off", {31'd0, rider_off}, 1);

        // en low mid-STEER.
        set_ld('h180, 'h180);
        cycles(1);
        count_to_steer("steer_again", 400, SETTLE);
        en = 1'b0;
        cycles(1);
        chk("en_low_state", {30'd0, state_o}, 0);

        // rst mid-WAIT at timer 0x80, then a full settle on re-entry.
        en = 1'b1;
        cycles(1);
        chk("wait_again", {30'd0, state_o}, 1);
        cycles(128);
        rst = 1'b1;
        cycles(1);
        chk("midwait_rst_state", {30'd0, state_o}, 0);
        chk("midwait_rst_rider_off", {31'd0, rider_off}, 1);
        rst = 1'b0;
        cycles(1);
        chk("reenter_wait", {30'd0, state_o}, 1);
        count_to_steer("full_settle_after_rst", 400, SETTLE);

        cycles(2);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
